// File: rtl/dsss_spreader.sv
`default_nettype none
// ============================================================================
// Module  : dsss_spreader
// Brief   : Serialises DATA_W-bit words MSB first and spreads each bit into
//           SPREAD chips by XOR with a runtime-loadable code.
// Rev     : 1.0
// ============================================================================
module dsss_spreader #(
    parameter int                DATA_W    = 8,
    parameter int                SPREAD    = 24,
    parameter logic [SPREAD-1:0] CODE_INIT = SPREAD'(24'hF13A65)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_readi,
    input  logic [SPREAD-1:0] i_code,
    input  logic              i_code_we,
    output logic              o_data,
    output logic              o_valid,
    output logic              o_last,
    input  logic              i_ready
);

    localparam int c_CW = (SPREAD > 1) ? $clog2(SPREAD) : 1;
    localparam int c_BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_CW-1:0] c_CHIP_LAST = c_CW'(SPREAD - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(DATA_W - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [DATA_W-1:0]   r_buf;
    logic                r_buf_full;
    logic                r_readi;
    logic [DATA_W-1:0]   r_shift, w_shift_nxt;
    logic [c_BW-1:0]     r_bit_cnt, w_bit_nxt;
    logic [c_CW-1:0]     r_chip_cnt, w_chip_nxt;
    logic [c_CW-1:0]     w_chip_idx;
    logic [SPREAD-1:0]   r_code_act, w_code_act_nxt;
    logic [SPREAD-1:0]   r_code_pend;
    logic                r_odata, w_odata_nxt;
    logic                r_ovalid, w_ovalid_nxt;
    logic                r_olast, w_olast_nxt;
    logic                w_load;
    logic                w_emit;
    logic                w_accept;
    logic                w_buf_full_nxt;

    assign w_accept       = i_valid & r_readi;
    assign w_buf_full_nxt = w_accept | (r_buf_full & ~w_load);

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_nxt      = r_bit_cnt;
        w_chip_nxt     = r_chip_cnt;
        w_code_act_nxt = r_code_act;
        w_odata_nxt    = r_odata;
        w_ovalid_nxt   = r_ovalid;
        w_olast_nxt    = r_olast;
        w_load         = 1'b0;
        w_emit         = 1'b0;
        w_chip_idx     = '0;

        case (r_state)
            S_IDLE: begin
                w_odata_nxt  = 1'b0;
                w_ovalid_nxt = 1'b0;
                w_olast_nxt  = 1'b0;
                if (r_buf_full) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // The output register holds its chip until downstream takes it.
                if (i_ready || !r_ovalid) begin
                    if (r_olast) begin
                        if (r_buf_full) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt  = S_IDLE;
                            w_odata_nxt  = 1'b0;
                            w_ovalid_nxt = 1'b0;
                            w_olast_nxt  = 1'b0;
                        end
                    end else begin
                        w_emit = 1'b1;
                        if (r_chip_cnt == c_CHIP_LAST) begin
                            w_chip_nxt  = '0;
                            w_shift_nxt = r_shift << 1;
                            w_bit_nxt   = r_bit_cnt + c_BW'(1);
                        end else begin
                            w_chip_nxt = r_chip_cnt + c_CW'(1);
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // A new word takes the code pending before this edge.
        if (w_load) begin
            w_emit         = 1'b1;
            w_shift_nxt    = r_buf;
            w_bit_nxt      = '0;
            w_chip_nxt     = '0;
            w_code_act_nxt = r_code_pend;
        end

        if (w_emit) begin
            w_chip_idx   = c_CHIP_LAST - w_chip_nxt;
            w_ovalid_nxt = 1'b1;
            w_odata_nxt  = w_shift_nxt[DATA_W-1] ^ w_code_act_nxt[w_chip_idx];
            w_olast_nxt  = (w_bit_nxt == c_BIT_LAST) && (w_chip_nxt == c_CHIP_LAST);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_buf       <= '0;
            r_buf_full  <= 1'b0;
            r_readi     <= 1'b0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_chip_cnt  <= '0;
            r_code_act  <= CODE_INIT;
            r_code_pend <= CODE_INIT;
            r_odata     <= 1'b0;
            r_ovalid    <= 1'b0;
            r_olast     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            if (w_accept) begin
                r_buf <= i_data;
            end
            r_buf_full <= w_buf_full_nxt;
            r_readi    <= ~w_buf_full_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_chip_cnt <= w_chip_nxt;
            r_code_act <= w_code_act_nxt;
            if (i_code_we) begin
                r_code_pend <= i_code;
            end
            r_odata    <= w_odata_nxt;
            r_ovalid   <= w_ovalid_nxt;
            r_olast    <= w_olast_nxt;
        end
    end

    assign o_readi = r_readi;
    assign o_data  = r_odata;
    assign o_valid = r_ovalid;
    assign o_last  = r_olast;

endmodule
`default_nettype wire

// File: tb/tb_dsss_spreader.sv
`default_nettype none
// ============================================================================
// Module  : tb_dsss_spreader
// Brief   : Self-checking bench for dsss_spreader (1-bit and 8-bit instances).
// Rev     : 1.0
// ============================================================================
module tb_dsss_spreader;

    typedef struct {
        logic d;
        logic last;
        int   cyc;
    } chip_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] code;
    logic        code_we;
    logic        d1, v1, readi1, od1, ov1, ol1, rdy1;
    logic [7:0]  d8;
    logic        v8, readi8, od8, ov8, ol8, rdy8;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    chip_t mon1_q[$];
    chip_t mon8_q[$];
    chip_t exp8_q[$];

    dsss_spreader #(.DATA_W(1), .SPREAD(24), .CODE_INIT(24'hF13A65)) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_data(d1), .i_valid(v1), .o_readi(readi1),
        .i_code(code), .i_code_we(code_we), .o_data(od1), .o_valid(ov1),
        .o_last(ol1), .i_ready(rdy1)
    );

    dsss_spreader #(.DATA_W(8), .SPREAD(24), .CODE_INIT(24'hF13A65)) u_dut8 (
        .i_clk(clk), .i_reset(rst), .i_data(d8), .i_valid(v8), .o_readi(readi8),
        .i_code(code), .i_code_we(code_we), .o_data(od8), .o_valid(ov8),
        .o_last(ol8), .i_ready(rdy8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every chip that will be consumed at the coming rising edge.
    always @(negedge clk) begin
        if (ov1 === 1'b1 && rdy1 === 1'b1) mon1_q.push_back('{d: od1, last: ol1, cyc: cyc});
        if (ov8 === 1'b1 && rdy8 === 1'b1) mon8_q.push_back('{d: od8, last: ol8, cyc: cyc});
    end

    // Reference: word MSB first, each bit spread over the code MSB first.
    task automatic model_word8(input logic [7:0] w, input logic [23:0] c);
        for (int b = 7; b >= 0; b--)
            for (int k = 0; k < 24; k++)
                exp8_q.push_back('{d: w[b] ^ c[23-k], last: (b == 0 && k == 23), cyc: 0});
    endtask

    task automatic send_word8(input logic [7:0] w);
        bit ok = 1'b0;
        d8 = w;
        v8 = 1'b1;
        for (int t = 0; t < 2000 && !ok; t++) begin
            @(negedge clk);
            ok = (readi8 === 1'b1);
            @(posedge clk); #1;
        end
        v8 = 1'b0;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL send_word accept: got no accept, want accept of %h", w); end
    endtask

    task automatic wait_chips8(input int n);
        for (int t = 0; t < 20000 && mon8_q.size() < n; t++) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            n_checks++;
            if ({ov1, readi1, od1, ol1, ov8, readi8, od8, ol8} !== 8'b0) begin
                n_fail++;
                $display("FAIL reset outputs: got %b, want 00000000", {ov1, readi1, od1, ol1, ov8, readi8, od8, ol8});
            end
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({readi1, readi8} !== 2'b00) begin n_fail++; $display("FAIL ready before release edge: got %b, want 00", {readi1, readi8}); end
        @(posedge clk); #1;
        n_checks++;
        if ({readi1, readi8} !== 2'b11) begin n_fail++; $display("FAIL ready after release edge: got %b, want 11", {readi1, readi8}); end
    endtask

    task automatic test_single_bit();
        logic [23:0] pat;
        for (int w = 0; w < 2; w++) begin
            pat = (w == 0) ? 24'hF13A65 : 24'h0EC59A;
            mon1_q.delete();
            rdy1 = 1'b1;
            d1   = w[0];
            v1   = 1'b1;
            @(negedge clk);
            n_checks++;
            if (readi1 !== 1'b1) begin n_fail++; $display("FAIL bit%0d ready: got %b, want 1", w, readi1); end
            @(posedge clk); #1;
            v1 = 1'b0;
            n_checks++;
            if (ov1 !== 1'b0) begin n_fail++; $display("FAIL bit%0d valid at accept: got %b, want 0", w, ov1); end
            @(posedge clk); #1;
            n_checks++;
            if (ov1 !== 1'b1) begin n_fail++; $display("FAIL bit%0d latency: got valid=%b, want 1", w, ov1); end
            for (int t = 0; t < 200 && mon1_q.size() < 24; t++) begin @(posedge clk); #1; end
            n_checks++;
            if (ov1 !== 1'b0) begin n_fail++; $display("FAIL bit%0d valid after last: got %b, want 0", w, ov1); end
            repeat (3) @(posedge clk);
            #1;
            n_checks++;
            if (mon1_q.size() != 24) begin n_fail++; $display("FAIL bit%0d chip count: got %0d, want 24", w, mon1_q.size()); end
            for (int i = 0; i < 24 && i < mon1_q.size(); i++) begin
                n_checks++;
                if (mon1_q[i].d !== pat[23-i] || mon1_q[i].last !== (i == 23)) begin
                    n_fail++;
                    $display("FAIL bit%0d chip %0d: got d=%b last=%b, want d=%b last=%b", w, i, mon1_q[i].d, mon1_q[i].last, pat[23-i], (i == 23));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int gaps = 0;
        mon8_q.delete();
        exp8_q.delete();
        rdy8 = 1'b1;
        model_word8(8'hA5, 24'hF13A65);
        model_word8(8'h3C, 24'hF13A65);
        send_word8(8'hA5);
        n_checks++;
        if ({ov8, readi8} !== 2'b00) begin n_fail++; $display("FAIL b2b after accept: got valid,ready=%b, want 00", {ov8, readi8}); end
        @(posedge clk); #1;
        n_checks++;
        if ({ov8, readi8} !== 2'b11) begin n_fail++; $display("FAIL b2b after load: got valid,ready=%b, want 11", {ov8, readi8}); end
        send_word8(8'h3C);
        wait_chips8(100);
        n_checks++;
        if (readi8 !== 1'b0) begin n_fail++; $display("FAIL b2b ready while full: got %b, want 0", readi8); end
        wait_chips8(384);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({ov8, readi8} !== 2'b01) begin n_fail++; $display("FAIL b2b idle: got valid,ready=%b, want 01", {ov8, readi8}); end
        n_checks++;
        if (mon8_q.size() != exp8_q.size()) begin n_fail++; $display("FAIL b2b chip count: got %0d, want %0d", mon8_q.size(), exp8_q.size()); end
        for (int i = 0; i < exp8_q.size() && i < mon8_q.size(); i++) begin
            n_checks++;
            if (mon8_q[i].d !== exp8_q[i].d || mon8_q[i].last !== exp8_q[i].last) begin
                n_fail++;
                $display("FAIL b2b chip %0d: got d=%b last=%b, want d=%b last=%b", i, mon8_q[i].d, mon8_q[i].last, exp8_q[i].d, exp8_q[i].last);
            end
            if (i > 0 && mon8_q[i].cyc != mon8_q[i-1].cyc + 1) gaps++;
        end
        n_checks++;
        if (gaps != 0) begin n_fail++; $display("FAIL b2b contiguity: got %0d gaps, want 0", gaps); end
    endtask

    task automatic test_backpressure();
        logic [7:0] w;
        mon8_q.delete();
        exp8_q.delete();
        rdy8 = 1'b1;
        w = 8'($urandom);
        model_word8(w, 24'hF13A65);
        send_word8(w);
        wait_chips8(10);
        rdy8 = 1'b0;
        repeat (5) begin
            @(negedge clk);
            n_checks++;
            if (ov8 !== 1'b1 || od8 !== exp8_q[10].d || ol8 !== exp8_q[10].last) begin
                n_fail++;
                $display("FAIL stall hold: got v=%b d=%b l=%b, want v=1 d=%b l=%b", ov8, od8, ol8, exp8_q[10].d, exp8_q[10].last);
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (mon8_q.size() != 10) begin n_fail++; $display("FAIL stall consumed: got %0d, want 10", mon8_q.size()); end
        rdy8 = 1'b1;
        wait_chips8(192);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (mon8_q.size() != exp8_q.size()) begin n_fail++; $display("FAIL stall chip count: got %0d, want %0d", mon8_q.size(), exp8_q.size()); end
        for (int i = 0; i < exp8_q.size() && i < mon8_q.size(); i++) begin
            n_checks++;
            if (mon8_q[i].d !== exp8_q[i].d || mon8_q[i].last !== exp8_q[i].last) begin
                n_fail++;
                $display("FAIL stall chip %0d: got d=%b last=%b, want d=%b last=%b", i, mon8_q[i].d, mon8_q[i].last, exp8_q[i].d, exp8_q[i].last);
            end
        end
    endtask

    task automatic test_random_stream();
        logic [7:0] words[4];
        mon8_q.delete();
        exp8_q.delete();
        foreach (words[i]) begin
            words[i] = 8'($urandom);
            model_word8(words[i], 24'hF13A65);
        end
        fork
            begin
                foreach (words[i]) send_word8(words[i]);
            end
            begin
                for (int t = 0; t < 20000 && mon8_q.size() < 768; t++) begin
                    @(posedge clk); #1;
                    rdy8 = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rdy8 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (mon8_q.size() != exp8_q.size()) begin n_fail++; $display("FAIL random chip count: got %0d, want %0d", mon8_q.size(), exp8_q.size()); end
        for (int i = 0; i < exp8_q.size() && i < mon8_q.size(); i++) begin
            n_checks++;
            if (mon8_q[i].d !== exp8_q[i].d || mon8_q[i].last !== exp8_q[i].last) begin
                n_fail++;
                $display("FAIL random chip %0d: got d=%b last=%b, want d=%b last=%b", i, mon8_q[i].d, mon8_q[i].last, exp8_q[i].d, exp8_q[i].last);
            end
        end
    endtask

    task automatic test_code_update();
        logic [7:0] wa, wb;
        mon8_q.delete();
        exp8_q.delete();
        rdy8 = 1'b1;
        wa = 8'($urandom);
        wb = {1'b0, 7'($urandom)};
        model_word8(wa, 24'hF13A65);
        model_word8(wb, 24'h000001);
        send_word8(wa);
        wait_chips8(30);
        code    = 24'($urandom);
        code_we = 1'b1;
        @(posedge clk); #1;
        code    = 24'h000001;
        @(posedge clk); #1;
        code_we = 1'b0;
        code    = 24'($urandom);
        send_word8(wb);
        wait_chips8(384);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (mon8_q.size() != exp8_q.size()) begin n_fail++; $display("FAIL code chip count: got %0d, want %0d", mon8_q.size(), exp8_q.size()); end
        for (int i = 0; i < exp8_q.size() && i < mon8_q.size(); i++) begin
            n_checks++;
            if (mon8_q[i].d !== exp8_q[i].d || mon8_q[i].last !== exp8_q[i].last) begin
                n_fail++;
                $display("FAIL code chip %0d: got d=%b last=%b, want d=%b last=%b", i, mon8_q[i].d, mon8_q[i].last, exp8_q[i].d, exp8_q[i].last);
            end
        end
    endtask

    task automatic test_reset_midword();
        logic [7:0] w;
        mon8_q.delete();
        exp8_q.delete();
        rdy8 = 1'b1;
        send_word8(8'($urandom));
        send_word8(8'($urandom));
        wait_chips8(7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if ({ov8, readi8} !== 2'b00) begin n_fail++; $display("FAIL midreset outputs: got valid,ready=%b, want 00", {ov8, readi8}); end
        mon8_q.delete();
        @(posedge clk); #1;
        n_checks++;
        if (readi8 !== 1'b1) begin n_fail++; $display("FAIL midreset ready after release: got %b, want 1", readi8); end
        repeat (30) @(posedge clk);
        #1;
        n_checks++;
        if (mon8_q.size() != 0) begin n_fail++; $display("FAIL midreset stale chips: got %0d, want 0", mon8_q.size()); end
        w = 8'($urandom);
        model_word8(w, 24'hF13A65);
        send_word8(w);
        wait_chips8(192);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (mon8_q.size() != exp8_q.size()) begin n_fail++; $display("FAIL midreset chip count: got %0d, want %0d", mon8_q.size(), exp8_q.size()); end
        for (int i = 0; i < exp8_q.size() && i < mon8_q.size(); i++) begin
            n_checks++;
            if (mon8_q[i].d !== exp8_q[i].d || mon8_q[i].last !== exp8_q[i].last) begin
                n_fail++;
                $display("FAIL midreset chip %0d: got d=%b last=%b, want d=%b last=%b", i, mon8_q[i].d, mon8_q[i].last, exp8_q[i].d, exp8_q[i].last);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        code    = 24'h0;
        code_we = 1'b0;
        d1      = 1'b0;
        v1      = 1'b0;
        rdy1    = 1'b1;
        d8      = 8'h0;
        v8      = 1'b0;
        rdy8    = 1'b1;
        test_reset();
        test_single_bit();
        test_back_to_back();
        test_backpressure();
        test_random_stream();
        test_code_update();
        test_reset_midword();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dsss_spreader.md
Name: dsss_spreader

Overview:
- Parametrised successor to the single-bit chip spreader.
- Accepts DATA_W-bit words over a valid/ready handshake and serialises them MSB first.
- Spreads each bit into SPREAD chips by XOR with a runtime-loadable spreading code, with output back-pressure and a last-chip marker.
- Sits between the framer/bit source and the chip-rate modulator; one chip per clock when not stalled.

Parameters:
- DATA_W, 8, bits per input word (>=1).
- SPREAD, 24, chips per bit; code length (>=2).
- CODE_INIT, 24'hF13A65, spreading code after reset; bit SPREAD-1 is chip 0.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_data  in  DATA_W  input word.
- i_valid  in  1  i_data valid.
- o_readi  out  1  ready for a word; transfer on i_valid & o_readi.
- i_code  in  SPREAD  new spreading code.
- i_code_we  in  1  load i_code into the pending-code register.
- o_data  out  1  chip.
- o_valid  out  1  chip valid.
- o_last  out  1  high with the final chip of a word.
- i_ready  in  1  downstream accepts the chip; chip consumed on o_valid & i_ready.

Behaviour:
- Reset (i_reset=1 at a clock edge):
  - o_valid=0, o_data=0, o_last=0, o_readi=0.
  - Buffer empty; state IDLE; counters 0; active and pending code = CODE_INIT.
  - o_readi rises on the first edge with i_reset=0. Reset mid-word discards buffer and shifter; no further chips of that word appear.
- Input buffer: one DATA_W register plus buf_full.
  - o_readi is registered and equals ~buf_full, forced 0 in reset.
  - Accept sets buf_full. Transfer to the shifter clears it.
  - Accept and transfer on the same edge leave buf_full=1 with the new word.
- States:
  - IDLE: o_valid=0. If buf_full, load shifter, bit_cnt=0, chip_cnt=0, latch pending code into active code, emit chip 0, go to RUN. Latency: accept at edge N → o_valid=1 after edge N+1.
  - RUN: a step occurs when i_ready=1 or o_valid=0 (hold-when-stalled).
    - While i_ready=0 and o_valid=1, o_data, o_valid and o_last stay frozen.
    - Each step emits o_data = cur_bit XOR active_code[SPREAD-1-chip_cnt], then advances chip_cnt.
    - At chip_cnt=SPREAD-1, chip_cnt wraps to 0 and the shifter shifts left (next bit), bit_cnt+1.
    - o_last=1 when bit_cnt=DATA_W-1 and chip_cnt=SPREAD-1.
    - After the last chip is consumed: if buf_full, reload and emit chip 0 of the next word on the same edge (no bubble) and re-latch the pending code. Otherwise o_valid=0 and go to IDLE.
- Code update:
  - i_code_we writes the pending code at any time; last write wins.
  - The active code changes only at word load, never mid-word.
  - A write on the load edge is not used for that word.
- Throughput: with i_ready=1 and the buffer refilled before the last chip, output is DATA_W*SPREAD contiguous chips per word.
- Counters:
  - chip_cnt: clog2(SPREAD) bits.
  - bit_cnt: clog2(DATA_W) bits, min 1.
  - No count exceeds SPREAD-1 or DATA_W-1.
- i_data/i_valid ignored while o_readi=0. The source must hold them until accepted.

Test Plan:
- Reset/ready (DATA_W=1, SPREAD=24): 2-cycle reset → o_valid=0, o_readi=0 during reset; o_readi=1 one edge after release.
- Single bit: i_data=0, i_valid one cycle, i_ready=1 → o_valid 1 edge later; 24 chips = F13A65 MSB first (1,1,1,1,0,0,0,1,...); o_last on chip 24; o_valid=0 after. i_data=1 → 24 chips = 0EC59A.
- Back-to-back words (DATA_W=8): words A5, 3C with buffer refilled → 192 contiguous chips, o_last at chip 192 and 384, o_readi low only while buffer full.
- Back-pressure: i_ready=0 for 5 cycles at chip 10 → o_data/o_valid frozen; chip 11 follows on release; no chip lost or duplicated.
- Code update: i_code_we with 24'h000001 mid-word → current word still uses F13A65; next word bit 0 chips = 0…01.
- Reset mid-word after chip 7 → o_valid=0 next edge; buffered word dropped; o_readi=1 after release; new word starts at chip 0 with CODE_INIT.
